spi_slave_ctrl: RTL
===================

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 8, width of tx_data and the read-data payload shifted out on MISO.
REQ-002 Parameter WORD_SIZE, default 10, width of the received word rx_data, command bits [9:8] plus payload.
REQ-003 The block SHALL provide these ports:
- clk  input  1  sole clock; also the SPI bit clock; all sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  WORD_SIZE  assembled word to the memory.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  ADDR_SIZE  read data returned by the memory.
- tx_valid  input  1  tx_data valid strobe from the memory.

Function
REQ-004 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA and WAIT_TX.
REQ-005 IDLE: on SS_n=0, go to CHK_CMD next cycle; otherwise stay.
REQ-006 CHK_CMD: sample MOSI as the direction bit; MOSI=0 -> WRITE; MOSI=1 with rd_addr_seen=0 -> READ_ADD; MOSI=1 with rd_addr_seen=1 -> READ_DATA.
REQ-007 WRITE, READ_ADD and READ_DATA SHALL shift in exactly WORD_SIZE MOSI bits, MSB first, one per cycle, using a bit counter.
REQ-008 On the cycle after the last bit, rx_data SHALL hold the word and rx_valid SHALL be 1 for exactly one cycle; rx_valid is 0 at all other times.
REQ-009 After the rx_valid strobe: WRITE -> IDLE; READ_ADD -> IDLE with rd_addr_seen set to 1; READ_DATA -> WAIT_TX.
REQ-010 WAIT_TX: on tx_valid=1, latch tx_data, then drive it on MISO over the next ADDR_SIZE cycles, MSB first; afterwards clear rd_addr_seen and return to IDLE.
- A tx_valid arriving in any other state SHALL be ignored.
REQ-011 MISO SHALL be 0 whenever no read data is being shifted out.
REQ-012 SS_n=1 in any non-IDLE state SHALL force IDLE on the next edge:
- bit counter cleared;
- no rx_valid strobe issued;
- partial rx_data discarded;
- rd_addr_seen unchanged, unless the MISO shift was already under way, in which case it is cleared.
REQ-013 rx_data SHALL remain stable between strobes; only the internal shift register changes while bits are being received.

Reset
REQ-014 While rst_n=0 (asynchronous), the block SHALL hold: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counters=0, rd_addr_seen=0, tx shift register=0.
REQ-015 A reset asserted mid-frame SHALL abort the frame with no rx_valid strobe; after release, the block SHALL need a fresh SS_n falling edge (SS_n seen high, then low) before starting a frame.

Configuration
REQ-016 Macro SPI_RD_SEQ_CHECK_EN SHALL compile the read-sequence check in or out:
- Defined: a read-data word (rx_data[9:8]=2'b11) received while rd_addr_seen=0 is dropped with no rx_valid, and a READ_ADD word whose bits [9:8] are not 2'b10 is also dropped with no rx_valid and leaves rd_addr_seen unchanged.
- Undefined: every completed word is strobed unchanged, and REQ-006 routing alone decides the state.

Verification
REQ-017 Write address: SS_n=0, MOSI 0 then 10'b00_0000_0101 -> one rx_valid with rx_data=10'h005 after the 10th bit; FSM back in IDLE.
REQ-018 Write data: SS_n=0, MOSI 0 then 10'b01_1010_1010 -> rx_data=10'h1AA with a single-cycle rx_valid.
REQ-019 Read: frame 1 sends 1 + 10'h205 -> rx_data=10'h205, rd_addr_seen=1; frame 2 sends 1 + 10'h300, tx_valid with tx_data=8'hAA two cycles later -> MISO outputs 1,0,1,0,1,0,1,0 over 8 cycles, then rd_addr_seen=0.
REQ-020 Abort: SS_n raised after 5 of 10 WRITE bits -> no rx_valid, FSM in IDLE next cycle; the next full frame is received correctly.
REQ-021 Reset mid-shift: rst_n pulsed low during the MISO output of 8'hFF -> MISO=0 immediately, all outputs at reset values.
REQ-022 With SPI_RD_SEQ_CHECK_EN defined: a frame whose READ_ADD word has bits [9:8]=2'b11 -> no rx_valid and rd_addr_seen stays 0; without the macro -> rx_valid with rx_data=10'h3xx.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a small memory: frames command/address/data words from MOSI
// and returns read data on MISO. Optional read-order checking: define SPI_RD_SEQ_CHECK_EN.
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int BCW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int TCW = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [2:0] WAIT_TX   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-2:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic                 tx_active_q, tx_active_d;
  logic                 armed_q, armed_d;

  logic [WORD_SIZE-1:0] word_full;
  logic                 last_bit;
  logic                 last_tx_bit;
  logic                 drop_word;

  assign word_full   = {shift_q, MOSI};
  assign last_bit    = (bit_cnt_q == BCW'(WORD_SIZE - 1));
  assign last_tx_bit = (tx_cnt_q == TCW'(ADDR_SIZE - 1));

`ifdef SPI_RD_SEQ_CHECK_EN
  logic [1:0] cmd;
  assign cmd       = word_full[WORD_SIZE-1:WORD_SIZE-2];
  assign drop_word = ((cmd == 2'b11) && !rd_addr_seen_q) ||
                     ((state_q == READ_ADD) && (cmd != 2'b10));
`else
  assign drop_word = 1'b0;
`endif

  // A frame may only start once SS_n has been seen high since reset.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_active_d    = tx_active_q;
    armed_d        = armed_q | SS_n;

    if ((state_q != IDLE) && SS_n) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      tx_shift_d  = '0;
      tx_cnt_d    = '0;
      tx_active_d = 1'b0;
      if (tx_active_q) begin
        rd_addr_seen_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n && armed_q) begin
            state_d = CHK_CMD;
          end
        end

        CHK_CMD: begin
          bit_cnt_d = '0;
          shift_d   = '0;
          if (!MOSI) begin
            state_d = WRITE;
          end else if (rd_addr_seen_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (last_bit) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            state_d   = IDLE;
            if (!drop_word) begin
              rx_data_d  = word_full;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                rd_addr_seen_d = 1'b1;
              end
              if (state_q == READ_DATA) begin
                state_d = WAIT_TX;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shift_d   = word_full[WORD_SIZE-2:0];
          end
        end

        // MISO carries the latched byte for ADDR_SIZE cycles after tx_valid.
        WAIT_TX: begin
          if (!tx_active_q) begin
            if (tx_valid) begin
              tx_shift_d  = tx_data;
              tx_cnt_d    = '0;
              tx_active_d = 1'b1;
            end
          end else if (last_tx_bit) begin
            tx_shift_d     = '0;
            tx_cnt_d       = '0;
            tx_active_d    = 1'b0;
            rd_addr_seen_d = 1'b0;
            state_d        = IDLE;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            tx_cnt_d   = tx_cnt_q + TCW'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_active_q    <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_active_q    <= tx_active_d;
      armed_q        <= armed_d;
    end
  end

  assign MISO     = tx_active_q & tx_shift_q[ADDR_SIZE-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
